bus_addr_dec_tmo: RTL and testbench

Parametrised, registered bus address decoder with per-slave enable mask, bus-timeout watchdog and error capture. It sits between the bus arbiter's granted-master signals and the N slaves: it decodes the slave index from the top address bits and holds a one-hot active-low chip select for the whole transaction. It returns the selected slave's ready to the master, and produces an error response for unmapped slaves or slaves that never answer.

---
 rtl/bus_addr_dec_tmo_if.sv | 32 +++
 rtl/bus_addr_dec_tmo.sv | 134 +++++++++++++
 tb/tb_bus_addr_dec_tmo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_addr_dec_tmo_if.sv
// rtl/bus_addr_dec_tmo_if.sv - granted-master / slave-select bundle for the address decoder
interface bus_addr_dec_tmo_if #(
  parameter int ADDR_W     = 30,
  parameter int NUM_SLAVES = 8
);
  logic [ADDR_W-1:0]     s_addr;
  logic                  s_as_;
  logic                  s_rdy_;
  logic                  bus_err;
  logic [NUM_SLAVES-1:0] cs_;
  logic [NUM_SLAVES-1:0] slv_rdy_;

  // Decoder side: consumes the master's request and the slaves' readies
  modport slave (
    input  s_addr,
    input  s_as_,
    input  slv_rdy_,
    output cs_,
    output s_rdy_,
    output bus_err
  );

  // Requester side: drives the request and the slaves' readies
  modport master (
    output s_addr,
    output s_as_,
    output slv_rdy_,
    input  cs_,
    input  s_rdy_,
    input  bus_err
  );
endinterface

// File: rtl/bus_addr_dec_tmo.sv
// rtl/bus_addr_dec_tmo.sv - registered address decoder with enable mask, timeout watchdog and error capture
module bus_addr_dec_tmo #(
  parameter int ADDR_W     = 30,
  parameter int NUM_SLAVES = 8,
  parameter int TIMEOUT    = 255,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset_,
  bus_addr_dec_tmo_if.slave    bus,
  input  logic [NUM_SLAVES-1:0] en_mask,
  input  logic                 err_clr,
  output logic [1:0]           err_code,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int IDX_W = $clog2(NUM_SLAVES);
  // A zero TIMEOUT disables the watchdog; keep a 1-bit timer so the width stays legal
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_UNMAP = 2'b01;
  localparam logic [1:0] CODE_TMO   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      sel, sel_nxt;
  logic [ADDR_W-1:0]     addr_q, addr_nxt;
  logic [TMR_W-1:0]      timer, timer_nxt;
  logic [NUM_SLAVES-1:0] cs_q, cs_nxt;
  logic                  err_set;
  logic [1:0]            new_code;

  logic [IDX_W-1:0]      idx;
  logic                  sel_rdy;

  assign idx     = bus.s_addr[ADDR_W-1 -: IDX_W];
  // Only the selected slave's ready matters; all others are ignored
  assign sel_rdy = ~bus.slv_rdy_[sel];

  // Next-state, latch and chip-select decode; cs_ is precomputed so it leaves a flop
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    addr_nxt  = addr_q;
    timer_nxt = timer;
    cs_nxt    = '1;
    err_set   = 1'b0;
    new_code  = CODE_NONE;
    case (state)
      IDLE: begin
        if (!bus.s_as_) begin
          addr_nxt = bus.s_addr;
          if (en_mask[idx]) begin
            sel_nxt   = idx;
            timer_nxt = '0;
            state_nxt = BUSY;
            cs_nxt    = ~(NUM_SLAVES'(1) << idx);
          end else begin
            state_nxt = ERR;
            err_set   = 1'b1;
            new_code  = CODE_UNMAP;
          end
        end
      end
      BUSY: begin
        // Ready beats a coincident timeout
        if (sel_rdy) begin
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (timer == TMR_LAST)) begin
          state_nxt = ERR;
          err_set   = 1'b1;
          new_code  = CODE_TMO;
        end else begin
          if (TIMEOUT != 0) timer_nxt = timer + 1'b1;
          cs_nxt = ~(NUM_SLAVES'(1) << sel);
        end
      end
      ERR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transaction state, latched select/address, watchdog timer and chip selects
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state  <= IDLE;
      sel    <= '0;
      addr_q <= '0;
      timer  <= '0;
      cs_q   <= '1;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      addr_q <= addr_nxt;
      timer  <= timer_nxt;
      cs_q   <= cs_nxt;
    end
  end

  // Error capture on ERR entry; a new error overrides a simultaneous clear
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      err_code <= CODE_NONE;
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (err_set) begin
      err_code <= new_code;
      err_addr <= addr_nxt;
      if (err_clr)
        err_cnt <= ERR_CNT_W'(1);
      else if (!(&err_cnt))
        err_cnt <= err_cnt + 1'b1;
    end else if (err_clr) begin
      err_code <= CODE_NONE;
      err_cnt  <= '0;
    end
  end

  assign bus.cs_     = cs_q;
  assign bus.s_rdy_  = ~(((state == BUSY) && sel_rdy) || (state == ERR));
  assign bus.bus_err = (state == ERR);

endmodule

// File: tb/tb_bus_addr_dec_tmo.sv
// tb/tb_bus_addr_dec_tmo.sv - scoreboard bench for bus_addr_dec_tmo
module tb_bus_addr_dec_tmo;
  localparam int AW  = 30;
  localparam int NS  = 8;
  localparam int TMO = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          reset_;
  logic [NS-1:0] en_mask;
  logic          err_clr;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] err_cnt;

  bus_addr_dec_tmo_if #(.ADDR_W(AW), .NUM_SLAVES(NS)) bus ();

  bus_addr_dec_tmo #(
    .ADDR_W(AW), .NUM_SLAVES(NS), .TIMEOUT(TMO), .ERR_CNT_W(CW)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .bus     (bus.slave),
    .en_mask (en_mask),
    .err_clr (err_clr),
    .err_code(err_code),
    .err_addr(err_addr),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            end_cyc;
    bit            is_err;
    logic [1:0]    code;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0]    m_code;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction: strobe in cycle 0, selected ready low in cycle rdy_cyc (0 = never)
  task automatic run_txn(input logic [AW-1:0] addr, input int rdy_cyc,
                         input logic [NS-1:0] foreign, input bit clr);
    logic [2:0]    idx;
    bit            mapped;
    int            last_busy;
    bit            done;
    logic [NS-1:0] cs_busy;
    exp_t          e;
    idx     = addr[AW-1 -: 3];
    mapped  = en_mask[idx];
    cs_busy = ~(8'h01 << idx);
    if (!mapped) begin
      e.end_cyc = 1; e.is_err = 1'b1; e.code = 2'b01; last_busy = 0;
    end else if (rdy_cyc >= 1 && rdy_cyc <= TMO) begin
      e.end_cyc = rdy_cyc; e.is_err = 1'b0; e.code = m_code; last_busy = rdy_cyc;
    end else begin
      e.end_cyc = TMO + 1; e.is_err = 1'b1; e.code = 2'b10; last_busy = TMO;
    end
    if (e.is_err) begin
      m_code = e.code;
      m_addr = addr;
      m_cnt  = clr ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
    end
    e.code = m_code; e.addr = m_addr; e.cnt = m_cnt;
    sb.push_back(e);

    @(posedge clk); #1;
    bus.s_as_    = 1'b0;
    bus.s_addr   = addr;
    bus.slv_rdy_ = ~foreign;
    err_clr      = clr;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      bus.s_as_    = 1'b1;
      bus.s_addr   = AW'($urandom);
      err_clr      = 1'b0;
      bus.slv_rdy_ = ~foreign;
      if (c == rdy_cyc) bus.slv_rdy_[idx] = 1'b0;
      @(negedge clk);
      chk($sformatf("cs_c%0d", c), bus.cs_, (mapped && c <= last_busy) ? cs_busy : 8'hFF);
      if (!bus.s_rdy_) begin
        e = sb.pop_front();
        chk("end_cyc", c, e.end_cyc);
        chk("bus_err", bus.bus_err, e.is_err);
        chk("err_code", err_code, e.code);
        chk("err_addr", err_addr, e.addr);
        chk("err_cnt", err_cnt, e.cnt);
        done = 1'b1;
      end else begin
        chk("bus_err_quiet", bus.bus_err, 1'b0);
      end
    end
    if (!done) begin
      chk("rdy_seen", bus.s_rdy_, 1'b0);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    bus.slv_rdy_ = '1;
    @(negedge clk);
    chk("post_cs", bus.cs_, 8'hFF);
    chk("post_rdy", bus.s_rdy_, 1'b1);
    chk("post_err", bus.bus_err, 1'b0);
  endtask

  initial begin
    reset_       = 1'b0;
    bus.s_as_    = 1'b1;
    bus.s_addr   = '0;
    bus.slv_rdy_ = '1;
    en_mask      = 8'hFF;
    err_clr      = 1'b0;
    m_code = 2'b00; m_addr = '0; m_cnt = '0;

    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
    @(negedge clk);
    chk("rst_cs", bus.cs_, 8'hFF);
    chk("rst_rdy", bus.s_rdy_, 1'b1);
    chk("rst_berr", bus.bus_err, 1'b0);
    chk("rst_code", err_code, 2'b00);
    chk("rst_addr", err_addr, 30'h0);
    chk("rst_cnt", err_cnt, 8'h00);

    // Normal access to slave 3, ready in cycle 3
    run_txn({3'd3, 27'h10}, 3, 8'h00, 1'b0);

    // Unmapped slave 5
    en_mask = 8'hDF;
    run_txn({3'd5, 27'h2AB_CDEF}, 0, 8'h00, 1'b0);

    // Asynchronous reset in the middle of a BUSY transaction
    en_mask = 8'hFF;
    @(posedge clk); #1;
    bus.s_as_ = 1'b0; bus.s_addr = {3'd6, 27'h55};
    @(posedge clk); #1;
    bus.s_as_ = 1'b1;
    @(negedge clk);
    chk("busy_cs", bus.cs_, 8'hBF);
    #3 reset_ = 1'b0;
    #1;
    chk("arst_cs", bus.cs_, 8'hFF);
    chk("arst_rdy", bus.s_rdy_, 1'b1);
    chk("arst_berr", bus.bus_err, 1'b0);
    chk("arst_cnt", err_cnt, 8'h00);
    chk("arst_code", err_code, 2'b00);
    chk("arst_addr", err_addr, 30'h0);
    @(posedge clk); #1 reset_ = 1'b1;
    m_code = 2'b00; m_addr = '0; m_cnt = '0;

    // Timeout on slave 2, then ready exactly in the last allowed cycle
    run_txn({3'd2, 27'h1234}, 0, 8'h00, 1'b0);
    run_txn({3'd2, 27'h77}, TMO, 8'h00, 1'b0);

    // Slave 1 selected while slave 4 holds its ready low
    run_txn({3'd1, 27'h9}, 5, 8'h10, 1'b0);

    // Back-to-back accesses to every slave
    for (int i = 0; i < NS; i++)
      run_txn({3'(i), 27'($urandom)}, $urandom_range(1, 4), 8'h00, 1'b0);

    // Counter saturation
    en_mask = 8'h00;
    repeat (256) run_txn({3'($urandom_range(0, 7)), 27'($urandom)}, 0, 8'h00, 1'b0);
    chk("sat_cnt", err_cnt, 8'hFF);

    // Clear coincident with a new error
    en_mask = 8'hF7;
    run_txn({3'd3, 27'h3C3}, 0, 8'h00, 1'b1);
    chk("clr_err_cnt", err_cnt, 8'h01);

    // Clear alone
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", err_cnt, 8'h00);
    chk("clr_code", err_code, 2'b00);
    chk("clr_addr", err_addr, m_addr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
